neopixel_frame_scheduler: RTL and testbench

Sequences the neopixel_driver. Owns ping-pong frame-buffer bank selection, so the SPI writer fills the back bank while the driver streams the front bank. Issues driver start pulses on writer commit and on a periodic refresh timer. Supervises driver busy with timeouts and reports frame counts and errors to the control/status register block.

---
 rtl/neopixel_frame_scheduler_if.sv | 36 +++
 rtl/neopixel_frame_scheduler.sv | 149 ++++++++++++++
 tb/tb_neopixel_frame_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : neopixel_frame_scheduler_if
//  Brief    : Writer, driver and status signals of the neopixel frame scheduler.
//             The slave modport is the scheduler; the master modport is the
//             environment (writer, driver and CSR block).
//  Revision : 1.0  initial release
// ============================================================================
interface neopixel_frame_scheduler_if;
   logic        i_enable;
   logic        i_commit;
   logic        o_commit_ack;
   logic        o_wr_ready;
   logic        o_wr_bank;
   logic        o_drv_bank;
   logic        o_drv_start;
   logic        i_drv_busy;
   logic        o_frame_pulse;
   logic [15:0] o_frame_cnt;
   logic        o_err;
   logic [1:0]  o_err_code;
   logic        i_clr_err;

   modport slave (
      input  i_enable, i_commit, i_drv_busy, i_clr_err,
      output o_commit_ack, o_wr_ready, o_wr_bank, o_drv_bank, o_drv_start,
             o_frame_pulse, o_frame_cnt, o_err, o_err_code
   );

   modport master (
      output i_enable, i_commit, i_drv_busy, i_clr_err,
      input  o_commit_ack, o_wr_ready, o_wr_bank, o_drv_bank, o_drv_start,
             o_frame_pulse, o_frame_cnt, o_err, o_err_code
   );
endinterface
`default_nettype wire

// File: rtl/neopixel_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : neopixel_frame_scheduler
//  Brief    : Ping-pong bank ownership, driver start sequencing (commit and
//             periodic refresh), busy watchdog and frame/error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module neopixel_frame_scheduler #(
   parameter int unsigned REFRESH_TCK  = 500_000,
   parameter int unsigned START_TO_TCK = 8,
   parameter int unsigned FRAME_TO_TCK = 2_000_000
) (
   input  wire logic                  i_clk,
   input  wire logic                  i_rst,
   neopixel_frame_scheduler_if.slave  bus
);

   localparam logic [31:0] REFRESH_RELOAD = 32'(REFRESH_TCK - 1);
   localparam logic [31:0] START_LIMIT    = 32'(START_TO_TCK - 1);
   localparam logic [31:0] FRAME_LIMIT    = 32'(FRAME_TO_TCK - 1);
   localparam logic [1:0]  ERR_START      = 2'b01;
   localparam logic [1:0]  ERR_FRAME      = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SWAP      = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t      state_q;
   logic [31:0] refresh_cnt_q;
   logic        refresh_pending_q;
   logic        commit_pending_q;
   logic [31:0] wd_q;
   logic        drv_bank_q;
   logic        commit_ack_q;
   logic        drv_start_q;
   logic        frame_pulse_q;
   logic [15:0] frame_cnt_q;
   logic        err_q;
   logic [1:0]  err_code_q;
   logic        refresh_fire;

   // A zero period disables the refresh source entirely.
   assign refresh_fire = (REFRESH_TCK != 0) && (refresh_cnt_q == 32'd0);

   // Free-running refresh down-counter, independent of state and enable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         refresh_cnt_q <= REFRESH_RELOAD;
      end else if (REFRESH_TCK != 0) begin
         if (refresh_cnt_q == 32'd0) refresh_cnt_q <= REFRESH_RELOAD;
         else                         refresh_cnt_q <= refresh_cnt_q - 32'd1;
      end
   end

   // Sequencer: state, pending flags, watchdog, registered pulses, counters, errors.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q           <= S_IDLE;
         refresh_pending_q <= 1'b0;
         commit_pending_q  <= 1'b0;
         wd_q              <= 32'd0;
         drv_bank_q        <= 1'b0;
         commit_ack_q      <= 1'b0;
         drv_start_q       <= 1'b0;
         frame_pulse_q     <= 1'b0;
         frame_cnt_q       <= 16'd0;
         err_q             <= 1'b0;
         err_code_q        <= 2'b00;
      end else begin
         commit_ack_q  <= 1'b0;
         drv_start_q   <= 1'b0;
         frame_pulse_q <= 1'b0;
         // Saturating so a very long stall cannot wrap past the limits.
         if (wd_q != 32'hFFFF_FFFF) wd_q <= wd_q + 32'd1;
         // Clear first so a timeout in the same cycle overrides it.
         if (bus.i_clr_err) begin
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
         end
         // Pulses are registered on the transition, so each lands in the
         // cycle its state is occupied (ack in SWAP, start in START).
         case (state_q)
            S_IDLE: begin
               if (bus.i_enable && commit_pending_q) begin
                  state_q          <= S_SWAP;
                  drv_bank_q       <= ~drv_bank_q;
                  commit_ack_q     <= 1'b1;
                  commit_pending_q <= 1'b0;
               end else if (bus.i_enable && refresh_pending_q) begin
                  state_q           <= S_START;
                  drv_start_q       <= 1'b1;
                  refresh_pending_q <= 1'b0;
                  wd_q              <= 32'd0;
               end
            end
            S_SWAP: begin
               state_q           <= S_START;
               drv_start_q       <= 1'b1;
               refresh_pending_q <= 1'b0;
               wd_q              <= 32'd0;
            end
            S_START: begin
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.i_drv_busy) begin
                  state_q <= S_WAIT_DONE;
                  wd_q    <= 32'd0;
               end else if (wd_q == START_LIMIT) begin
                  state_q <= S_IDLE;
                  err_q   <= 1'b1;
                  if (!err_q || bus.i_clr_err) err_code_q <= ERR_START;
               end
            end
            S_WAIT_DONE: begin
               if (!bus.i_drv_busy) begin
                  state_q       <= S_IDLE;
                  frame_pulse_q <= 1'b1;
                  frame_cnt_q   <= frame_cnt_q + 16'd1;
               end else if (wd_q == FRAME_LIMIT) begin
                  state_q <= S_IDLE;
                  err_q   <= 1'b1;
                  if (!err_q || bus.i_clr_err) err_code_q <= ERR_FRAME;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Requests arriving on a clearing edge must not be lost.
         if (bus.i_commit) commit_pending_q  <= 1'b1;
         if (refresh_fire) refresh_pending_q <= 1'b1;
      end
   end

   assign bus.o_commit_ack  = commit_ack_q;
   assign bus.o_wr_ready    = ~commit_pending_q;
   assign bus.o_drv_bank    = drv_bank_q;
   assign bus.o_wr_bank     = ~drv_bank_q;
   assign bus.o_drv_start   = drv_start_q;
   assign bus.o_frame_pulse = frame_pulse_q;
   assign bus.o_frame_cnt   = frame_cnt_q;
   assign bus.o_err         = err_q;
   assign bus.o_err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_neopixel_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neopixel_frame_scheduler
//  Brief    : Scoreboard bench. dut_a (no refresh) exercises commits, frame
//             timeout, counter wrap and async reset; dut_b (refresh 1000)
//             exercises the refresh timer and start timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neopixel_frame_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   neopixel_frame_scheduler_if ifa ();
   neopixel_frame_scheduler_if ifb ();

   neopixel_frame_scheduler #(.REFRESH_TCK(0), .START_TO_TCK(8), .FRAME_TO_TCK(200)) dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (ifa.slave)
   );

   neopixel_frame_scheduler #(.REFRESH_TCK(1000), .START_TO_TCK(8), .FRAME_TO_TCK(200)) dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (ifb.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard for dut_a: cycle -1 means "any cycle".
   typedef struct {
      int   cyc;
      logic bank;
   } ev_t;
   ev_t         ack_q[$];
   ev_t         start_q[$];
   logic [15:0] frame_q[$];

   // Driver models: 0 = busy 100 cycles after start, 1 = never busy, 2 = stuck busy.
   int mode_a = 0;
   int mode_b = 0;

   initial begin : drv_a
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (rst_a !== 1'b0) begin
            cnt = 0; ifa.i_drv_busy = 1'b0;
         end else if (mode_a == 2) begin
            ifa.i_drv_busy = 1'b1;
         end else if (mode_a == 1) begin
            cnt = 0; ifa.i_drv_busy = 1'b0;
         end else begin
            if (cnt > 0) begin ifa.i_drv_busy = 1'b1; cnt--; end
            else ifa.i_drv_busy = 1'b0;
            if (ifa.o_drv_start) cnt = 100;
         end
      end
   end

   initial begin : drv_b
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (rst_b !== 1'b0) begin
            cnt = 0; ifb.i_drv_busy = 1'b0;
         end else if (mode_b == 2) begin
            ifb.i_drv_busy = 1'b1;
         end else if (mode_b == 1) begin
            cnt = 0; ifb.i_drv_busy = 1'b0;
         end else begin
            if (cnt > 0) begin ifb.i_drv_busy = 1'b1; cnt--; end
            else ifb.i_drv_busy = 1'b0;
            if (ifb.o_drv_start) cnt = 100;
         end
      end
   end

   // Output monitor for dut_a: every pulse must match a queued expectation.
   initial begin : mon_a
      ev_t  e;
      logic nb;
      forever begin
         @(negedge clk);
         if (rst_a === 1'b0) begin
            if (ifa.o_commit_ack) begin
               chk("ack_expected", 32'(ack_q.size() != 0), 1);
               if (ack_q.size() != 0) begin
                  e  = ack_q.pop_front();
                  nb = ~e.bank;
                  if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
                  chk("ack_drv_bank", ifa.o_drv_bank, e.bank);
                  chk("ack_wr_bank", ifa.o_wr_bank, nb);
               end
            end
            if (ifa.o_drv_start) begin
               chk("start_expected", 32'(start_q.size() != 0), 1);
               if (start_q.size() != 0) begin
                  e = start_q.pop_front();
                  if (e.cyc >= 0) chk("start_cycle", cyc, e.cyc);
                  chk("start_bank", ifa.o_drv_bank, e.bank);
               end
            end
            if (ifa.o_frame_pulse) begin
               chk("frame_expected", 32'(frame_q.size() != 0), 1);
               if (frame_q.size() != 0) chk("frame_cnt", ifa.o_frame_cnt, frame_q.pop_front());
            end
         end
      end
   end

   task automatic pulse_commit_a(output int c);
      @(negedge clk);
      c = cyc;
      ifa.i_commit = 1'b1;
      @(negedge clk);
      ifa.i_commit = 1'b0;
   endtask

   task automatic exp_commit_a(input int c, input logic bank);
      ack_q.push_back('{c + 2, bank});
      start_q.push_back('{c + 3, bank});
   endtask

   task automatic wait_sb_a(input int budget, input string tag);
      for (int i = 0; i < budget && (ack_q.size() + start_q.size() + frame_q.size()) != 0; i++)
         @(negedge clk);
      chk(tag, 32'(ack_q.size() + start_q.size() + frame_q.size()), 0);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_drv_bank"}, ifa.o_drv_bank, 0);
      chk({tag, "_wr_bank"}, ifa.o_wr_bank, 1);
      chk({tag, "_wr_ready"}, ifa.o_wr_ready, 1);
      chk({tag, "_start"}, ifa.o_drv_start, 0);
      chk({tag, "_ack"}, ifa.o_commit_ack, 0);
      chk({tag, "_frame_pulse"}, ifa.o_frame_pulse, 0);
      chk({tag, "_frame_cnt"}, ifa.o_frame_cnt, 0);
      chk({tag, "_err"}, ifa.o_err, 0);
      chk({tag, "_err_code"}, 32'(ifa.o_err_code), 0);
   endtask

   task automatic run_a();
      int c;
      bit seen;
      ifa.i_enable = 1'b0; ifa.i_commit = 1'b0; ifa.i_clr_err = 1'b0;
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      chk_reset_a("rst");

      // Single commit from IDLE: ack at +2, start at +3, then one frame.
      ifa.i_enable = 1'b1;
      pulse_commit_a(c);
      exp_commit_a(c, 1'b1);
      frame_q.push_back(16'd1);
      chk("wr_ready_pending", ifa.o_wr_ready, 0);
      @(negedge clk);
      chk("wr_ready_after_ack", ifa.o_wr_ready, 1);
      wait_sb_a(300, "t_commit_done");
      chk("t_commit_cnt", ifa.o_frame_cnt, 1);

      // Three commits during a busy frame collapse into one swap afterwards.
      pulse_commit_a(c);
      exp_commit_a(c, 1'b0);
      frame_q.push_back(16'd2);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = ifa.i_drv_busy; end
      chk("t_multi_busy", seen, 1);
      for (int k = 0; k < 3; k++) begin
         repeat (10) @(negedge clk);
         pulse_commit_a(c);
      end
      ack_q.push_back('{-1, 1'b1});
      start_q.push_back('{-1, 1'b1});
      frame_q.push_back(16'd3);
      wait_sb_a(400, "t_multi_done");
      repeat (20) @(negedge clk);
      chk("t_multi_bank", ifa.o_drv_bank, 1);
      chk("t_multi_cnt", ifa.o_frame_cnt, 3);

      // Busy stuck high: frame timeout, count unchanged, back to IDLE.
      mode_a = 2;
      pulse_commit_a(c);
      exp_commit_a(c, 1'b0);
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = ifa.o_err; end
      chk("fto_err", seen, 1);
      chk("fto_code", 32'(ifa.o_err_code), 2);
      chk("fto_cnt", ifa.o_frame_cnt, 3);
      wait_sb_a(10, "fto_sb");
      mode_a = 0;
      repeat (3) @(negedge clk);
      ifa.i_clr_err = 1'b1;
      @(negedge clk);
      ifa.i_clr_err = 1'b0;
      chk("fto_clr_err", ifa.o_err, 0);
      chk("fto_clr_code", 32'(ifa.o_err_code), 0);
      pulse_commit_a(c);
      exp_commit_a(c, 1'b1);
      frame_q.push_back(16'd4);
      wait_sb_a(300, "fto_recover");
      chk("fto_recover_err", ifa.o_err, 0);

      // Frame counter wrap.
      @(negedge clk);
      force dut_a.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut_a.frame_cnt_q;
      @(negedge clk);
      chk("wrap_preload", ifa.o_frame_cnt, 16'hFFFF);
      pulse_commit_a(c);
      exp_commit_a(c, 1'b0);
      frame_q.push_back(16'h0000);
      wait_sb_a(300, "wrap_done");
      chk("wrap_cnt", ifa.o_frame_cnt, 0);

      // Async reset in the middle of WAIT_DONE.
      pulse_commit_a(c);
      exp_commit_a(c, 1'b1);
      repeat (20) @(negedge clk);
      chk("arst_busy_before", ifa.i_drv_busy, 1);
      chk("arst_bank_before", ifa.o_drv_bank, 1);
      wait_sb_a(1, "arst_sb");
      @(posedge clk);
      #2;
      rst_a = 1'b1;
      #1;
      chk_reset_a("arst");
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      repeat (10) @(negedge clk);
      chk("arst_idle_start", ifa.o_drv_start, 0);
   endtask

   task automatic run_b();
      int          starts[$];
      bit          bank_moved;
      bit          seen;
      int          s;
      int          e;
      logic [15:0] f0;
      bank_moved = 0; s = 0; e = 0;
      ifb.i_enable = 1'b1; ifb.i_commit = 1'b0; ifb.i_clr_err = 1'b0;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;

      // Refresh-only operation: starts every 1000 cycles from bank 0.
      for (int i = 0; i < 5100; i++) begin
         @(negedge clk);
         if (ifb.o_drv_start) starts.push_back(cyc);
         if (ifb.o_drv_bank !== 1'b0) bank_moved = 1;
      end
      chk("refresh_starts", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++)
         chk("refresh_period", starts[i] - starts[i-1], 1000);
      chk("refresh_bank_moved", bank_moved, 0);

      // Driver never goes busy: start timeout 8 cycles after the start pulse.
      mode_b = 1;
      seen = 0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         @(negedge clk);
         if (ifb.o_drv_start) begin seen = 1; s = cyc; end
      end
      chk("sto_start_seen", seen, 1);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (ifb.o_err) begin seen = 1; e = cyc; end
      end
      chk("sto_err_seen", seen, 1);
      chk("sto_latency", e - s, 8);
      chk("sto_code", 32'(ifb.o_err_code), 1);
      @(negedge clk);
      ifb.i_clr_err = 1'b1;
      @(negedge clk);
      ifb.i_clr_err = 1'b0;
      chk("sto_clr_err", ifb.o_err, 0);
      chk("sto_clr_code", 32'(ifb.o_err_code), 0);

      // Next refresh restarts a normal frame.
      mode_b = 0;
      f0 = ifb.o_frame_cnt;
      seen = 0;
      for (int i = 0; i < 1200 && !seen; i++) begin @(negedge clk); seen = ifb.o_drv_start; end
      chk("sto_restart", seen, 1);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = ifb.o_frame_pulse; end
      chk("sto_restart_frame", seen, 1);
      chk("sto_restart_cnt", ifb.o_frame_cnt, 16'(f0 + 16'd1));
      chk("sto_restart_err", ifb.o_err, 0);
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got still running required finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
